// File: rtl/vertexinput_reg_desc_pkg.sv
// vertexinput_reg_desc_pkg: register descriptor table, response codes and FSM state types
package vertexinput_reg_desc_pkg;

    localparam int NUM_REGS_DEFAULT = 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WIDLE, WRESP} wr_state_t;
    typedef enum logic {RIDLE, RDATA} rd_state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] rw;
        logic [31:0] w1c;
        logic [31:0] wo;
        logic [31:0] rc;
        logic [31:0] ro;
        logic [31:0] pulse;
    } reg_desc_t;

    // Control register: stored controls, two write-only strobes, one start pulse
    localparam reg_desc_t REG_DESC_0 = '{
        address: 32'h0000_0000, rw: 32'h07FF_FFFC, w1c: 32'h0, wo: 32'h0000_0003,
        rc: 32'h0, ro: 32'h0, pulse: 32'h0800_0000};
    // Status register: live status byte, read-clear counters, sticky w1c errors
    localparam reg_desc_t REG_DESC_1 = '{
        address: 32'h0000_0008, rw: 32'h0, w1c: 32'hFFFF_0000, wo: 32'h0,
        rc: 32'h0000_FF00, ro: 32'h0000_00FF, pulse: 32'h0};

    function automatic reg_desc_t get_desc(input int i);
        return (i == 1) ? REG_DESC_1 : REG_DESC_0;
    endfunction

endpackage

// File: rtl/vertexinput_axil_slave_if.sv
// vertexinput_axil_slave_if: AXI-lite write/read handshake FSMs feeding a register bank
module vertexinput_axil_slave_if
    import vertexinput_reg_desc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  o_wr_commit,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [DATA_W-1:0]     o_wr_data,
    output logic [DATA_W/8-1:0]   o_wr_strb,
    output logic                  o_rd_req,
    output logic [ADDR_W-1:0]     o_rd_addr,
    input  logic [DATA_W-1:0]     i_rd_data,
    input  logic                  i_rd_err,
    input  logic                  i_wr_err
);

    wr_state_t r_wstate, w_wstate_nxt;
    rd_state_t r_rstate, w_rstate_nxt;
    logic r_aw_held, r_w_held;

    assign o_rd_addr = s_araddr;
    assign s_bvalid  = (r_wstate == WRESP);
    assign s_rvalid  = (r_rstate == RDATA);

    // Write FSM next state; readies gated by aresetn so they read 0 while in reset
    always_comb begin
        w_wstate_nxt = r_wstate;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        o_wr_commit  = 1'b0;
        if (r_wstate == WIDLE) begin
            s_awready   = aresetn & ~r_aw_held;
            s_wready    = aresetn & ~r_w_held;
            o_wr_commit = r_aw_held & r_w_held;
            w_wstate_nxt = o_wr_commit ? WRESP : WIDLE;
        end else if (s_bready) begin
            w_wstate_nxt = WIDLE;
        end
    end

    // Write channel capture, commit and response hold
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= WIDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_wr_strb <= '0;
            s_bresp   <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (s_awvalid && s_awready) begin
                r_aw_held <= 1'b1;
                o_wr_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_w_held  <= 1'b1;
                o_wr_data <= s_wdata;
                o_wr_strb <= s_wstrb;
            end
            if (o_wr_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                s_bresp   <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read FSM next state; a request is the AR handshake itself
    always_comb begin
        s_arready    = aresetn & (r_rstate == RIDLE);
        o_rd_req     = s_arready & s_arvalid;
        w_rstate_nxt = o_rd_req ? RDATA : (s_rvalid && s_rready) ? RIDLE : r_rstate;
    end

    // Read data/response captured at the AR handshake and held until rready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate <= RIDLE;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (o_rd_req) begin
                s_rdata <= i_rd_err ? '0 : i_rd_data;
                s_rresp <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: rtl/vertexinput_csr_regfile.sv
// vertexinput_csr_regfile: AXI-lite CSR bank for vertex input; VERTEXINPUT_CSR_IRQ_EN enables irq_o
module vertexinput_csr_regfile
    import vertexinput_reg_desc_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [ADDR_W-1:0]          s_awaddr,
    input  logic                       s_awvalid,
    output logic                       s_awready,
    input  logic [DATA_W-1:0]          s_wdata,
    input  logic [DATA_W/8-1:0]        s_wstrb,
    input  logic                       s_wvalid,
    output logic                       s_wready,
    output logic [1:0]                 s_bresp,
    output logic                       s_bvalid,
    input  logic                       s_bready,
    input  logic [ADDR_W-1:0]          s_araddr,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [DATA_W-1:0]          s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic [NUM_REGS*DATA_W-1:0] ctrl_o,
    output logic [NUM_REGS*DATA_W-1:0] pulse_o,
    input  logic [NUM_REGS*DATA_W-1:0] status_i,
    input  logic [NUM_REGS*DATA_W-1:0] event_i,
    output logic                       irq_o
);

    logic                             w_wr_commit, w_rd_req, w_rd_err, w_wr_err;
    logic [ADDR_W-1:0]                w_wr_addr, w_rd_addr;
    logic [DATA_W-1:0]                w_wr_data, w_rd_data, w_lane;
    logic [DATA_W/8-1:0]              w_wr_strb;
    logic [NUM_REGS-1:0]              w_wr_hit, w_rd_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0]  w_rd_val;

    vertexinput_axil_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .o_wr_commit(w_wr_commit), .o_wr_addr(w_wr_addr), .o_wr_data(w_wr_data),
        .o_wr_strb(w_wr_strb), .o_rd_req(w_rd_req), .o_rd_addr(w_rd_addr),
        .i_rd_data(w_rd_data), .i_rd_err(w_rd_err), .i_wr_err(w_wr_err)
    );

    assign w_wr_err = ~|w_wr_hit;
    assign w_rd_err = ~|w_rd_hit;

    // Byte-lane expansion of wstrb and OR-combination of the per-register read values
    always_comb begin
        w_lane    = '0;
        w_rd_data = '0;
        for (int b = 0; b < DATA_W/8; b++) w_lane[b*8 +: 8] = {8{w_wr_strb[b]}};
        for (int i = 0; i < NUM_REGS; i++) w_rd_data = w_rd_data | w_rd_val[i];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam reg_desc_t D = get_desc(g);
        localparam logic [DATA_W-1:0] M_ST = DATA_W'(D.rw | D.wo);
        localparam logic [DATA_W-1:0] M_W1C = DATA_W'(D.w1c);
        localparam logic [DATA_W-1:0] M_RC = DATA_W'(D.rc);
        localparam logic [DATA_W-1:0] M_EV = DATA_W'(D.w1c | D.rc);
        localparam logic [DATA_W-1:0] M_RD = DATA_W'(D.rw | D.w1c | D.rc);
        localparam logic [DATA_W-1:0] M_RO = DATA_W'(D.ro);
        localparam logic [DATA_W-1:0] M_PU = DATA_W'(D.pulse);
        logic [DATA_W-1:0] r_store, r_pulse, w_wr_nxt, w_nxt, w_wbits;
        logic w_wsel, w_rsel;
        assign w_wr_hit[g] = (w_wr_addr == ADDR_W'(D.address));
        assign w_rd_hit[g] = (w_rd_addr == ADDR_W'(D.address));
        assign w_wsel  = w_wr_commit & w_wr_hit[g];
        assign w_rsel  = w_rd_req & w_rd_hit[g];
        assign w_wbits = w_wr_data & w_lane;
        // Write effects first, then read-clear, then event set so events always win
        assign w_wr_nxt = w_wsel ? (((r_store & ~(w_lane & M_ST)) | (w_wbits & M_ST)) & ~(w_wbits & M_W1C)) : r_store;
        assign w_nxt = (w_rsel ? (w_wr_nxt & ~M_RC) : w_wr_nxt) | (event_i[g*DATA_W +: DATA_W] & M_EV);
        assign w_rd_val[g] = w_rd_hit[g] ? ((r_store & M_RD) | (status_i[g*DATA_W +: DATA_W] & M_RO)) : '0;
        assign ctrl_o[g*DATA_W +: DATA_W]  = r_store & M_ST;
        assign pulse_o[g*DATA_W +: DATA_W] = r_pulse;
        // Stored bits and one-cycle pulses following a committed write
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_store <= '0;
                r_pulse <= '0;
            end else begin
                r_store <= w_nxt & (M_ST | M_EV);
                r_pulse <= w_wsel ? (w_wbits & M_PU) : '0;
            end
        end
    end

`ifdef VERTEXINPUT_CSR_IRQ_EN
    logic [NUM_REGS-1:0] w_w1c_any;
    logic                r_irq;
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_irq
        assign w_w1c_any[g] = |(g_reg[g].r_store & DATA_W'(get_desc(g).w1c));
    end
    // Interrupt follows any pending w1c bit one cycle later
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_irq <= 1'b0;
        else          r_irq <= |w_w1c_any;
    end
    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

endmodule
